// File: rtl/user_module_descrambler_rx.sv
// Serial descrambler receiver tile: LFSR-keyed bit stream in, recovered byte out as a nibble mux.
// Build option: define RX_PARITY_CHECK_EN for 9-bit frames carrying a trailing even-parity bit.
module user_module_descrambler_rx (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  logic       w_clk;
  logic       w_rst;
  logic       w_rx_bit;
  logic       w_rx_en;
  logic       w_sof;
  logic [1:0] w_seed_sel;
  logic       w_nib_sel;

  assign w_clk      = io_in[0];
  assign w_rst      = io_in[1];
  assign w_rx_bit   = io_in[2];
  assign w_rx_en    = io_in[3];
  assign w_sof      = io_in[4];
  assign w_seed_sel = io_in[6:5];
  assign w_nib_sel  = io_in[7];

  state_t     r_state, w_state;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_lfsr, w_lfsr;
  logic [7:0] r_data, w_data;
  logic [2:0] r_count, w_count;
  logic       r_strobe, w_strobe;
  logic       r_perr, w_perr;
  logic       r_abort, w_abort;
  logic       r_busy;
  logic [7:0] w_seed;
  logic [7:0] w_shift_in;
  logic       w_parity_out;

  always_comb begin
    case (w_seed_sel)
      2'b00:   w_seed = 8'hA5;
      2'b01:   w_seed = 8'h3C;
      2'b10:   w_seed = 8'hFF;
      default: w_seed = 8'h01;
    endcase
  end

  // Descrambled bit joins the shift register MSB-first
  assign w_shift_in = {r_shift[6:0], w_rx_bit ^ r_lfsr[7]};

  // Next-state and datapath; sof outranks every other event
  always_comb begin
    w_state  = r_state;
    w_shift  = r_shift;
    w_lfsr   = r_lfsr;
    w_data   = r_data;
    w_count  = r_count;
    w_strobe = 1'b0;
    w_perr   = r_perr;
    w_abort  = r_abort;
    if (w_sof) begin
      if (r_state != S_IDLE) w_abort = 1'b1;
      w_state = S_DATA;
      w_lfsr  = w_seed;
      w_count = 3'd0;
      w_shift = 8'h00;
    end else begin
      case (r_state)
        S_DATA: begin
          if (w_rx_en) begin
            w_shift = w_shift_in;
            w_lfsr  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            w_count = r_count + 3'd1;
            if (r_count == 3'd7) begin
`ifdef RX_PARITY_CHECK_EN
              w_state = S_PARITY;
`else
              w_data   = w_shift_in;
              w_strobe = 1'b1;
              w_abort  = 1'b0;
              w_state  = S_IDLE;
`endif
            end
          end
        end
`ifdef RX_PARITY_CHECK_EN
        S_PARITY: begin
          if (w_rx_en) begin
            w_data   = r_shift;
            w_strobe = 1'b1;
            w_perr   = (^r_shift) ^ w_rx_bit;
            w_abort  = 1'b0;
            w_state  = S_IDLE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'h00;
      r_lfsr   <= 8'h00;
      r_data   <= 8'h00;
      r_count  <= 3'd0;
      r_strobe <= 1'b0;
      r_perr   <= 1'b0;
      r_abort  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_shift  <= w_shift;
      r_lfsr   <= w_lfsr;
      r_data   <= w_data;
      r_count  <= w_count;
      r_strobe <= w_strobe;
      r_perr   <= w_perr;
      r_abort  <= w_abort;
      r_busy   <= (w_state != S_IDLE);
    end
  end

`ifdef RX_PARITY_CHECK_EN
  assign w_parity_out = r_perr;
`else
  assign w_parity_out = 1'b0;
`endif

  assign io_out = {r_abort, r_busy, w_parity_out, r_strobe,
                   (w_nib_sel ? r_data[7:4] : r_data[3:0])};

endmodule

// File: doc/user_module_descrambler_rx.md
Name: user_module_descrambler_rx

Overview:
- Tiny-tile serial receiver. Takes a scrambled, bit-serial byte stream on io_in and descrambles it with an 8-bit LFSR keystream.
- Checks even parity. Presents the recovered byte one nibble at a time on io_out, with status flags.
- Serves as the decode/receive end for the team's XOR-keyed scrambling tiles. It plugs into the standard 8-in/8-out user slot.

Parameters:
- none; slot pinout is fixed at 8 in / 8 out

Ports:
- io_in[0]  input  1  clock; all state updates on rising edge
- io_in[1]  input  1  reset; synchronous, active-high
- io_in[2]  input  1  rx_bit: serial scrambled data, MSB first
- io_in[3]  input  1  rx_en: bit strobe; rx_bit is sampled only on edges where rx_en=1
- io_in[4]  input  1  sof: start of frame; sampled every edge, independent of rx_en
- io_in[6:5]  input  2  seed_sel: LFSR seed, 00=8'hA5, 01=8'h3C, 10=8'hFF, 11=8'h01
- io_in[7]  input  1  nib_sel: 0 = low nibble on io_out[3:0], 1 = high nibble
- io_out[3:0]  output  4  selected nibble of last completed byte (combinational mux of registered byte)
- io_out[4]  output  1  byte_strobe: one-cycle pulse per completed frame
- io_out[5]  output  1  parity_err, status of last completed frame
- io_out[6]  output  1  busy: FSM not IDLE
- io_out[7]  output  1  abort: sticky flag, set when a frame was cut short by sof

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, data_reg=8'h00, shift=0, count=0, lfsr=8'h00, and all flags 0. Result: io_out=8'h00.
- FSM states: IDLE, DATA, PARITY.
  - IDLE: sof=1 -> DATA, lfsr<=seed(seed_sel), count<=0. rx_en is ignored in IDLE.
  - DATA: on each edge with rx_en=1:
    - d = rx_bit ^ lfsr[7]
    - shift <= {shift[6:0], d}
    - lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}
    - count <= count+1
  - DATA: when the 8th bit is accepted (count==7), go to PARITY.
  - PARITY: on the edge with rx_en=1, the parity bit p is taken raw (not descrambled). That same edge does all of:
    - data_reg <= shift
    - byte_strobe <= 1 for exactly one cycle
    - parity_err <= ^shift ^ p (even parity; error when 1)
    - abort <= 0
    - state <= IDLE
- sof while in DATA or PARITY restarts the frame:
  - abort <= 1; partial byte is discarded; data_reg and parity_err are unchanged.
  - Re-seed the LFSR, count<=0, stay/enter DATA.
  - sof has priority over rx_en on the same edge; that edge's rx_bit is ignored.
- sof and the completing parity bit on the same edge: sof wins, the frame is aborted, and no strobe is issued.
- Latency: recovered byte is visible on io_out the cycle after the edge that samples the parity bit.
- rx_en=0 cycles stall the FSM indefinitely. There is no timeout.
- busy = (state != IDLE), registered with the state.
- Reset mid-frame: sync reset dominates all other inputs. The partial frame is lost and abort is not set.

Optional Feature:
- Macro: RX_PARITY_CHECK_EN.
- Defined: 9-bit frames with the PARITY state as above.
- Undefined:
  - 8-bit frames; the PARITY state is removed.
  - Byte completion (data_reg update, byte_strobe) happens on the edge accepting the 8th data bit, so latency drops by one bit period.
  - io_out[5] is tied to 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> io_out=8'h00 after the first reset edge.
- Good frame: seed_sel=10 (keystream FF), sof, then rx_bits 1,0,1,0,0,1,0,1 and parity 0, all with rx_en=1. Required response:
  - nib_sel=0 -> io_out[3:0]=4'hA; nib_sel=1 -> 4'h5 (byte 8'h5A)
  - byte_strobe high exactly 1 cycle, parity_err=0, busy back to 0
- Parity error: same frame with parity bit 1 -> byte 8'h5A, parity_err=1, strobe pulses once.
- Stall: same good frame with 0-3 random rx_en=0 cycles between bits -> identical result to the unstalled frame; busy=1 throughout.
- Abort: sof, 4 bits, then sof again plus a full good frame. Required response:
  - abort=1 from the edge after the second sof
  - single strobe with 8'h5A
  - abort clears to 0 at that strobe
- Without RX_PARITY_CHECK_EN: 8-bit good frame (no parity bit) -> strobe on the 8th-bit edge +1 cycle, byte 8'h5A, io_out[5]=0.
